// File: rtl/mult_datapath_if.sv
// Command/operand/result bundle between the multiplier control FSM (master)
// and the shift-add datapath (slave).
interface mult_datapath_if #(parameter int WIDTH = 8);
   logic               Load;
   logic               Add_En;
   logic               Sub_En;
   logic               Shift_En;
   logic [WIDTH-1:0]   Mcand;
   logic [WIDTH-1:0]   Mplier;
   logic               M;
   logic               X;
   logic [WIDTH-1:0]   Aval;
   logic [WIDTH-1:0]   Bval;
   logic [2*WIDTH-1:0] Product;
   logic               Done;
   logic               Err;

   modport master (
      output Load, Add_En, Sub_En, Shift_En, Mcand, Mplier,
      input  M, X, Aval, Bval, Product, Done, Err
   );

   modport slave (
      input  Load, Add_En, Sub_En, Shift_En, Mcand, Mplier,
      output M, X, Aval, Bval, Product, Done, Err
   );
endinterface

// File: rtl/mult_datapath.sv
// X/A/B register chain and multiplicand latch for the signed shift-add multiplier.
// Define MULT_DP_CHECK_EN to build the sticky protocol checker driving Err.
module mult_datapath #(
   parameter int WIDTH = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   mult_datapath_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] s_q, a_q, b_q;
   logic             x_q;
   logic [CW-1:0]    cnt_q;
   logic             done_q;
   logic             err_q;
   logic [WIDTH:0]   sum;

   // One sign-extended adder serves both add and subtract, so -(-2^(W-1)) fits.
   always_comb begin
      sum = '0;
      if (bus.Sub_En)
         sum = {a_q[WIDTH-1], a_q} - {s_q[WIDTH-1], s_q};
      else
         sum = {a_q[WIDTH-1], a_q} + {s_q[WIDTH-1], s_q};
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         s_q    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         x_q    <= 1'b0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (bus.Load) begin
         s_q    <= bus.Mcand;
         b_q    <= bus.Mplier;
         a_q    <= '0;
         x_q    <= 1'b0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (bus.Sub_En || bus.Add_En) begin
         x_q <= sum[WIDTH];
         a_q <= sum[WIDTH-1:0];
      end else if (bus.Shift_En) begin
         a_q <= {x_q, a_q[WIDTH-1:1]};
         b_q <= {a_q[0], b_q[WIDTH-1:1]};
         // Counter saturates at WIDTH; extra shifts still move the data.
         if (cnt_q != CW'(WIDTH)) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1))
               done_q <= 1'b1;
         end
      end
   end

`ifdef MULT_DP_CHECK_EN
   logic multi_cmd, over_shift;

   assign multi_cmd  = ({1'b0, bus.Load} + {1'b0, bus.Add_En} +
                        {1'b0, bus.Sub_En} + {1'b0, bus.Shift_En}) > 2'd1;
   assign over_shift = bus.Shift_En && (cnt_q == CW'(WIDTH));

   // Load clears the flag even when it arrives together with other strobes.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         err_q <= 1'b0;
      else if (bus.Load)
         err_q <= 1'b0;
      else if (multi_cmd || over_shift)
         err_q <= 1'b1;
   end
`else
   assign err_q = 1'b0;
`endif

   assign bus.M       = b_q[0];
   assign bus.X       = x_q;
   assign bus.Aval    = a_q;
   assign bus.Bval    = b_q;
   assign bus.Product = {a_q, b_q};
   assign bus.Done    = done_q;
   assign bus.Err     = err_q;
endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mult_datapath;
   localparam int WIDTH = 8;
`ifdef MULT_DP_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [15:0] prod;
      logic        x;
      logic        m;
      logic        done;
      logic        err;
   } exp_t;

   logic Clk;
   logic Reset;
   mult_datapath_if #(.WIDTH(WIDTH)) bus ();

   mult_datapath #(.WIDTH(WIDTH)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (bus.Product !== e.prod || {bus.Aval, bus.Bval} !== e.prod ||
             bus.X !== e.x || bus.M !== e.m || bus.Done !== e.done || bus.Err !== e.err) begin
            errors++;
            $display("FAIL %s: got prod=%h ab=%h x=%b m=%b done=%b err=%b, want prod=%h x=%b m=%b done=%b err=%b",
                     e.name, bus.Product, {bus.Aval, bus.Bval}, bus.X, bus.M, bus.Done, bus.Err,
                     e.prod, e.x, e.m, e.done, e.err);
         end
      end
   end

   task automatic expect_out(input string name, input logic [15:0] prod,
                             input logic x, input logic m, input logic done, input logic err);
      exp_t e;
      e.name = name; e.prod = prod; e.x = x; e.m = m; e.done = done; e.err = err;
      q.push_back(e);
   endtask

   // One FSM cycle: drive strobes, let one rising edge sample them, then drop them.
   task automatic step(input logic ld, input logic ad, input logic sb, input logic sh,
                       input logic [7:0] mc, input logic [7:0] mp);
      @(negedge Clk); #1;
      bus.Load = ld; bus.Add_En = ad; bus.Sub_En = sb; bus.Shift_En = sh;
      bus.Mcand = mc; bus.Mplier = mp;
      @(posedge Clk); #1;
      bus.Load = 1'b0; bus.Add_En = 1'b0; bus.Sub_En = 1'b0; bus.Shift_En = 1'b0;
   endtask

   // Add-or-skip then shift, as the control FSM would, for pairs first..last.
   task automatic fsm_pairs(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         if (bus.M) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
         step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      end
   endtask

   initial begin
      Reset = 1'b0;
      bus.Load = 1'b0; bus.Add_En = 1'b0; bus.Sub_En = 1'b0; bus.Shift_En = 1'b0;
      bus.Mcand = 8'h00; bus.Mplier = 8'h00;
      #1 expect_out("reset_state", 16'h0000, 0, 0, 0, 0);
      @(negedge Clk); #1 Reset = 1'b1;

      // Add then shift
      step(1, 0, 0, 0, 8'h05, 8'h01); expect_out("add_load",  16'h0001, 0, 1, 0, 0);
      step(0, 1, 0, 0, 8'h00, 8'h00); expect_out("add_once",  16'h0501, 0, 1, 0, 0);
      step(0, 0, 0, 1, 8'h00, 8'h00); expect_out("add_shift", 16'h0280, 0, 0, 0, 0);
      step(0, 0, 0, 0, 8'h00, 8'h00); expect_out("idle_hold", 16'h0280, 0, 0, 0, 0);

      // 7 * -3
      step(1, 0, 0, 0, 8'h07, 8'hFD); expect_out("sgn_load",  16'h00FD, 0, 1, 0, 0);
      fsm_pairs(0, 6);
      step(0, 0, 1, 0, 8'h00, 8'h00); expect_out("sgn_sub",   16'hFFD7, 1, 1, 0, 0);
      step(0, 0, 0, 1, 8'h00, 8'h00); expect_out("sgn_final", 16'hFFEB, 1, 1, 1, 0);
      step(0, 0, 0, 1, 8'h00, 8'h00); expect_out("over_shift", 16'hFFF5, 1, 1, 1, CHK);

      // -128 * -128
      step(1, 0, 0, 0, 8'h80, 8'h80); expect_out("ext_load",  16'h0080, 0, 0, 0, 0);
      fsm_pairs(0, 6);
      step(0, 0, 1, 0, 8'h00, 8'h00); expect_out("ext_sub",   16'h8001, 0, 1, 0, 0);
      step(0, 0, 0, 1, 8'h00, 8'h00); expect_out("ext_final", 16'h4000, 0, 0, 1, 0);

      // Add and Shift together: add wins
      step(1, 0, 0, 0, 8'h03, 8'h00); expect_out("cfl_load",  16'h0000, 0, 0, 0, 0);
      step(0, 1, 0, 1, 8'h00, 8'h00); expect_out("cfl_both",  16'h0300, 0, 0, 0, CHK);
      step(0, 0, 0, 0, 8'h00, 8'h00); expect_out("cfl_sticky", 16'h0300, 0, 0, 0, CHK);
      step(1, 0, 0, 0, 8'h03, 8'h00); expect_out("cfl_clear", 16'h0000, 0, 0, 0, 0);

      // Asynchronous reset after 3 shifts, checked before the next rising edge
      step(1, 0, 0, 0, 8'h07, 8'hFD);
      fsm_pairs(0, 2);
      @(posedge Clk); #1;
      Reset = 1'b0;
      expect_out("async_reset", 16'h0000, 0, 0, 0, 0);
      @(negedge Clk); #1 Reset = 1'b1;
      step(0, 0, 0, 1, 8'h00, 8'h00); expect_out("post_reset_shift", 16'h0000, 0, 0, 0, 0);

      @(negedge Clk); @(negedge Clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mult_datapath.md
# mult_datapath

Register and arithmetic datapath for the 8-bit signed shift-add multiplier. It sits directly downstream of the multiplier control FSM and executes that FSM's one-cycle commands: Load, Add_En, Sub_En and Shift_En. It returns M, the current multiplier LSB, which the FSM uses to choose between add and skip. It holds the X/A/B register chain and the latched multiplicand S, and presents the 2·WIDTH-bit product to the display/hex stage.

## Interface
- WIDTH, 8, operand width; the product is 2·WIDTH bits.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Load  in  1  capture the operands, clear A/X/counter.
- Add_En  in  1  {X,A} ← A + S (signed).
- Sub_En  in  1  {X,A} ← A − S (signed).
- Shift_En  in  1  arithmetic right shift of X:A:B.
- Mcand  in  WIDTH  multiplicand S; sampled only on Load.
- Mplier  in  WIDTH  multiplier B; sampled only on Load.
- M  out  1  B[0]; combinational from the register.
- X  out  1  sign-extension bit.
- Aval  out  WIDTH  upper product register A.
- Bval  out  WIDTH  lower product register B.
- Product  out  2·WIDTH  {Aval,Bval}.
- Done  out  1  high once WIDTH shifts have completed since the last Load.
- Err  out  1  sticky protocol error; see Configuration.

## Operation
- Registers: S[WIDTH], A[WIDTH], B[WIDTH], X, shift counter cnt (clog2(WIDTH+1) bits), Done, Err.
- Exactly one command acts per cycle. Priority is Load > Sub_En > Add_En > Shift_En. Lower-priority commands asserted in the same cycle are ignored.
- Load: S←Mcand, B←Mplier, A←0, X←0, cnt←0, Done←0, Err←0.
- Add_En: form a (WIDTH+1)-bit sum {A[W-1],A}+{S[W-1],S}. X←sum[W], A←sum[W-1:0]. B, S and cnt are unchanged.
- Sub_En: identical to Add_En but uses {A[W-1],A}−{S[W-1],S}. This is a two's-complement subtract, so −S of the most negative value is handled by the 9-bit width.
- Shift_En: X unchanged, A←{X,A[W-1:1]}, B←{A[0],B[W-1:1]}.
  - If cnt<WIDTH: cnt←cnt+1.
  - Done←1 when the incremented cnt equals WIDTH.
  - If cnt is already WIDTH: the shift is still performed, cnt saturates, Done stays 1.
- No command asserted: all registers hold.
- M=B[0] at all times, so the FSM sees the new LSB in the cycle after a shift.

## Timing
- Reset low, at any time, including mid-multiply: every register clears immediately to 0 (S, A, B, X, cnt, Done, Err). This makes M=0, Product=0, Done=0 and Err=0.
- Release of Reset is synchronized by the consumer. The first command is honoured on the first rising edge after release.
- Every command is sampled on a rising edge. Its result is visible on the outputs after that edge, so latency is 1 cycle. There is no handshake; commands are single-cycle strobes from the FSM.
- Full multiply: Load, then WIDTH add/skip–shift pairs, with Sub replacing Add on the final pair. The product is valid and Done=1 in the cycle after the WIDTH-th shift.
- A Load held high for several cycles reloads on each cycle; this is harmless.

## Configuration
- MULT_DP_CHECK_EN defined: Err is set, and stays set until the next Load or Reset, on either of these events:
  - two or more commands asserted in the same cycle;
  - Shift_En arriving while cnt==WIDTH.
- MULT_DP_CHECK_EN undefined: the checker logic is not built and Err is tied to 0. Datapath behaviour is identical in both builds.

## Test plan
- Reset: assert Reset low mid-sequence, after 3 shifts → Product=0x0000, X=0, M=0, Done=0 on the same cycle, with no clock edge needed.
- Signed multiply: Load with Mcand=0x07, Mplier=0xFD, then drive the FSM-style add/shift sequence with Sub on the last pair → Product=0xFFEB (−21), X=1, Done=1.
- Extreme operands: Mcand=0x80, Mplier=0x80 → Product=0x4000. Sub of −128 gives A=0x80 with X=0 before the final shift.
- Add: Load Mcand=0x05, Mplier=0x01, then one Add_En → A=0x05, X=0, M=1. Follow with Shift_En → A=0x02, B=0x80, M=0, cnt=1.
- Conflict (MULT_DP_CHECK_EN defined): Add_En and Shift_En in the same cycle with A=0, S=0x03 → A=0x03, no shift, Err=1. Err stays 1 until the next Load, which clears it to 0.
- Over-shift (MULT_DP_CHECK_EN defined): a ninth Shift_En after Done → the shift is applied, Done stays 1, Err=1. With the macro undefined, Err remains 0.
